// File: rtl/stepper_cmd_gen_if.sv
// rtl/stepper_cmd_gen_if.sv - move command handshake between command stage and sequencer
interface stepper_cmd_gen_if #(
    parameter int STEP_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic [STEP_W-1:0] cmd_steps;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_steps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_steps,
        output cmd_ready
    );
endinterface

// File: rtl/stepper_cmd_gen.sv
// rtl/stepper_cmd_gen.sv - switch synchronise/debounce and move command framing
module stepper_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int N_FULL          = 200,
    parameter int STEP_W          = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         switches,
    stepper_cmd_gen_if.master  cmd,
    output logic               busy,
    output logic               err_multi
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEPS_FULL = STEP_W'(N_FULL);
    localparam logic [STEP_W-1:0] STEPS_HALF = STEP_W'(N_FULL >> 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ISSUE  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        sync1, sync2;
    logic [2:0]        sw_db, sw_db_q;
    logic [CNT_W-1:0]  db_cnt [3];
    logic              chg;
    logic              pending, pending_nxt;
    logic              load;
    logic              code_valid;
    logic              code_dir;
    logic [STEP_W-1:0] code_steps;
    logic              dir_q;
    logic [STEP_W-1:0] steps_q;
    logic              hs;

    // Two-stage synchroniser; the raw switch inputs go nowhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= switches;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce: a bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_db  <= '0;
            db_cnt <= '{default: '0};
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == sw_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_MAX) begin
                    db_cnt[i] <= '0;
                    sw_db[i]  <= ~sw_db[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Previous debounced value, used to detect a settled change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sw_db_q <= '0;
        else        sw_db_q <= sw_db;
    end

    assign chg = (sw_db != sw_db_q);

    // One-hot setting to move command; anything else yields no command.
    always_comb begin
        code_valid = 1'b0;
        code_dir   = 1'b0;
        code_steps = '0;
        case (sw_db)
            3'b100: begin code_valid = 1'b1; code_dir = 1'b1; code_steps = STEPS_FULL; end
            3'b010: begin code_valid = 1'b1; code_dir = 1'b1; code_steps = STEPS_HALF; end
            3'b001: begin code_valid = 1'b1; code_dir = 1'b0; code_steps = STEPS_FULL; end
            default: ;
        endcase
    end

    assign hs = cmd.cmd_valid && cmd.cmd_ready;

    // FSM state and one-deep pending flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
        end
    end

    // Next state: a change seen while busy is remembered and re-decoded from the latest sw_db.
    // A pending flag left over when returning to IDLE starts a fresh decode on its own.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        load        = 1'b0;
        case (state)
            IDLE: begin
                if (chg || pending) begin
                    state_nxt   = DECODE;
                    pending_nxt = 1'b0;
                end
            end
            DECODE: begin
                if (code_valid) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = IDLE;
                end
                if (chg) pending_nxt = 1'b1;
            end
            ISSUE: begin
                if (hs) begin
                    if (pending) begin
                        state_nxt   = DECODE;
                        pending_nxt = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                if (chg) pending_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command payload is captured in DECODE and frozen while the command is offered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q   <= 1'b0;
            steps_q <= '0;
        end else if (load) begin
            dir_q   <= code_dir;
            steps_q <= code_steps;
        end
    end

    assign cmd.cmd_valid = (state == ISSUE);
    assign cmd.cmd_dir   = dir_q;
    assign cmd.cmd_steps = steps_q;
    assign busy          = (state != IDLE) || pending;
    assign err_multi     = (state == DECODE) && !code_valid && (sw_db != 3'b000);
endmodule

// File: tb/tb_stepper_cmd_gen.sv
// tb/tb_stepper_cmd_gen.sv - directed self-checking bench for stepper_cmd_gen
module tb_stepper_cmd_gen;
    logic       clk;
    logic       rst_n;
    logic [2:0] switches;
    logic       busy;
    logic       err_multi;

    int total = 0;
    int bad   = 0;

    int valid_cnt = 0;
    int err_cnt   = 0;
    int hs_cnt    = 0;
    logic        last_dir   = 1'b0;
    logic [15:0] last_steps = '0;

    stepper_cmd_gen_if #(.STEP_W(16)) cmd_if ();

    stepper_cmd_gen #(
        .DEBOUNCE_CYCLES(1024),
        .N_FULL         (200),
        .STEP_W         (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .switches (switches),
        .cmd      (cmd_if),
        .busy     (busy),
        .err_multi(err_multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe on the falling edge; inputs change 1 time unit after the rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_if.cmd_valid) valid_cnt++;
            if (err_multi)        err_cnt++;
            if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
                hs_cnt++;
                last_dir   = cmd_if.cmd_dir;
                last_steps = cmd_if.cmd_steps;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int n;
    int hs0, vc0, ec0;

    initial begin
        rst_n             = 1'b0;
        switches          = 3'b000;
        cmd_if.cmd_ready  = 1'b0;
        cycles(3);
        check("rst_valid", {31'd0, cmd_if.cmd_valid}, 0);
        check("rst_dir",   {31'd0, cmd_if.cmd_dir},   0);
        check("rst_steps", {16'd0, cmd_if.cmd_steps}, 0);
        check("rst_busy",  {31'd0, busy},             0);
        check("rst_err",   {31'd0, err_multi},        0);
        rst_n = 1'b1;
        cycles(3);

        // 1: full forward, latency from input change to cmd_valid
        cmd_if.cmd_ready = 1'b1;
        switches         = 3'b100;
        n = 0;
        while (!cmd_if.cmd_valid && n < 3000) begin
            cycles(1);
            n++;
        end
        check("t1_latency", n, 1028);
        check("t1_dir",   {31'd0, cmd_if.cmd_dir},   1);
        check("t1_steps", {16'd0, cmd_if.cmd_steps}, 200);
        cycles(5);
        check("t1_hs",    hs_cnt, 1);
        check("t1_valid_drop", {31'd0, cmd_if.cmd_valid}, 0);
        check("t1_busy",  {31'd0, busy}, 0);
        check("t1_vcnt",  valid_cnt, 1);

        // 2: glitch shorter than the debounce window
        vc0 = valid_cnt;
        switches = 3'b010;
        cycles(500);
        switches = 3'b100;
        cycles(1500);
        check("t2_no_valid", valid_cnt, vc0);
        check("t2_busy", {31'd0, busy}, 0);

        // 3: two bits set -> single error pulse, no command
        vc0 = valid_cnt;
        ec0 = err_cnt;
        switches = 3'b110;
        cycles(1200);
        check("t3_err_pulse", err_cnt - ec0, 1);
        check("t3_no_valid", valid_cnt, vc0);
        check("t3_busy", {31'd0, busy}, 0);

        // 4: command held while switches change, latest setting follows
        hs0 = hs_cnt;
        cmd_if.cmd_ready = 1'b0;
        switches = 3'b100;
        cycles(1100);
        check("t4_valid_held", {31'd0, cmd_if.cmd_valid}, 1);
        check("t4_dir_a",   {31'd0, cmd_if.cmd_dir},   1);
        check("t4_steps_a", {16'd0, cmd_if.cmd_steps}, 200);
        switches = 3'b001;
        cycles(1100);
        check("t4_dir_held",   {31'd0, cmd_if.cmd_dir},   1);
        check("t4_steps_held", {16'd0, cmd_if.cmd_steps}, 200);
        check("t4_busy", {31'd0, busy}, 1);
        check("t4_no_hs", hs_cnt, hs0);
        cmd_if.cmd_ready = 1'b1;
        cycles(10);
        check("t4_hs2", hs_cnt - hs0, 2);
        check("t4_dir_b",   {31'd0, last_dir}, 0);
        check("t4_steps_b", {16'd0, last_steps}, 200);
        check("t4_idle", {31'd0, busy}, 0);

        // 5: half move, then all off gives nothing
        hs0 = hs_cnt;
        switches = 3'b010;
        cycles(1100);
        check("t5_hs", hs_cnt - hs0, 1);
        check("t5_dir",   {31'd0, last_dir}, 1);
        check("t5_steps", {16'd0, last_steps}, 100);
        hs0 = hs_cnt;
        ec0 = err_cnt;
        switches = 3'b000;
        cycles(1100);
        check("t5_off_no_hs", hs_cnt, hs0);
        check("t5_off_no_err", err_cnt, ec0);
        check("t5_off_busy", {31'd0, busy}, 0);

        // 6: asynchronous reset while a command is offered
        cmd_if.cmd_ready = 1'b0;
        switches = 3'b100;
        cycles(1100);
        check("t6_valid_pre", {31'd0, cmd_if.cmd_valid}, 1);
        rst_n = 1'b0;
        #1;
        check("t6_valid_async", {31'd0, cmd_if.cmd_valid}, 0);
        check("t6_busy_async",  {31'd0, busy}, 0);
        switches = 3'b000;
        cycles(3);
        rst_n = 1'b1;
        vc0 = valid_cnt;
        cycles(1500);
        check("t6_no_replay", valid_cnt, vc0);
        check("t6_busy", {31'd0, busy}, 0);
        hs0 = hs_cnt;
        cmd_if.cmd_ready = 1'b1;
        switches = 3'b001;
        cycles(1100);
        check("t6_new_hs", hs_cnt - hs0, 1);
        check("t6_new_dir",   {31'd0, last_dir}, 0);
        check("t6_new_steps", {16'd0, last_steps}, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
